// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, tick divider helper and receiver FSM states
package uart_pkg;

    localparam int CLK_FREQ_DEF   = 100000000;
    localparam int BAUD_DEF       = 9600;
    localparam int OVERSAMPLE_DEF = 16;

    function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    localparam int TICK_DIV_DEF = tick_div(CLK_FREQ_DEF, BAUD_DEF, OVERSAMPLE_DEF);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - free-running oversample tick, one-cycle pulse per TICK_DIV clocks
module uart_tick_gen #(
    parameter int TICK_DIV = 651
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and mid-bit sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BAUD       = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);

    rx_state_t  state, state_next;
    logic       rx_meta, rx_s, rx_prev;
    logic       tick, clr;
    logic [3:0] tcnt, tcnt_next;
    logic [2:0] idx, idx_next;
    logic [7:0] shift, shift_next;
    logic [7:0] data_next;
    logic       dv_next, fe_next;

    uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (clr),
        .tick   (tick)
    );

    // Synchronizer and edge-history flops reset high so the line reads idle.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            idx        <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            tcnt       <= tcnt_next;
            idx        <= idx_next;
            shift      <= shift_next;
            data_out   <= data_next;
            data_valid <= dv_next;
            frame_err  <= fe_next;
        end
    end

    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        idx_next   = idx;
        shift_next = shift;
        data_next  = data_out;
        dv_next    = 1'b0;
        fe_next    = 1'b0;
        clr        = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s && rx_prev) begin
                    clr        = 1'b1;
                    tcnt_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                // Eight ticks in lands mid start bit; a high line there was a glitch.
                if (tick) begin
                    if (tcnt == 4'd7) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            tcnt_next  = '0;
                            idx_next   = '0;
                            state_next = DATA;
                        end
                    end else begin
                        tcnt_next = tcnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tcnt_next = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        shift_next[idx] = rx_s;
                        idx_next        = idx + 3'd1;
                        if (idx == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tcnt_next = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        if (rx_s) begin
                            data_next  = shift;
                            dv_next    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            fe_next    = 1'b1;
                            state_next = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
